// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers producer writes and feeds
// them one at a time through a newd/donetx handshake, with a gap between frames.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     donetx,
    output logic                     newd,
    output logic [WIDTH-1:0]         dintx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             newd_r;
    logic             newd_next_s;
    logic [WIDTH-1:0] dintx_r;
    logic             donetx_d_r;
    logic             wr_ok_s;
    logic             pop_s;
    logic             done_rise_s;
    state_t           state_r;
    state_t           state_next_s;

    // Full is the registered flag, so a write while full is dropped even if a pop
    // happens on the same edge.
    assign wr_ok_s      = wr_en & ~full_r;
    assign done_rise_s  = donetx & ~donetx_d_r;
    assign count_next_s = count_r + CW'(wr_ok_s) - CW'(pop_s);

    // Send FSM next-state and pop decision.
    always_comb begin
        state_next_s = state_r;
        newd_next_s  = newd_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r) begin
                    pop_s        = 1'b1;
                    newd_next_s  = 1'b1;
                    state_next_s = SEND;
                end else begin
                    newd_next_s  = 1'b0;
                end
            end
            SEND: begin
                if (done_rise_s) begin
                    newd_next_s  = 1'b0;
                    state_next_s = GAP;
                end else begin
                    newd_next_s  = 1'b1;
                end
            end
            GAP: begin
                newd_next_s  = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                newd_next_s  = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register and donetx history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            donetx_d_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            donetx_d_r <= donetx;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CW'(DEPTH));
            empty_r    <= (count_next_s == {CW{1'b0}});
            overflow_r <= wr_en & full_r;
        end
    end

    // Transmitter-facing outputs; dintx holds the last byte sent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            newd_r  <= 1'b0;
            dintx_r <= {WIDTH{1'b0}};
        end else begin
            newd_r <= newd_next_s;
            if (pop_s) begin
                dintx_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign newd     = newd_r;
    assign dintx    = dintx_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a hand-derived vector table, directed corner sequences,
// and random traffic, all checked every cycle against a queue-based reference.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             donetx;
    logic             newd;
    logic [WIDTH-1:0] dintx;
    logic             full;
    logic             empty;
    logic [4:0]       count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference: pending bytes, in-flight flag, frames to wait before the next send.
    logic [7:0] q[$];
    logic [7:0] dut_log[$];
    logic       m_sending;
    logic       m_prev_done;
    logic       m_ovf;
    logic [7:0] m_last;
    int         m_skip;
    logic       prev_newd;

    typedef struct {
        logic       r;
        logic       we;
        logic [7:0] d;
        logic       dn;
        logic       e_newd;
        logic [7:0] e_dintx;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[14];

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .donetx   (donetx),
        .newd     (newd),
        .dintx    (dintx),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic we, input logic [7:0] d, input logic dn);
        int pre;
        if (!r) begin
            q.delete();
            m_sending   = 1'b0;
            m_prev_done = 1'b0;
            m_ovf       = 1'b0;
            m_last      = 8'h00;
            m_skip      = 0;
        end else begin
            pre   = q.size();
            m_ovf = we && (pre == DEPTH);
            if (m_sending) begin
                if (dn && !m_prev_done) begin
                    m_sending = 1'b0;
                    m_skip    = 1;
                end
            end else if (m_skip > 0) begin
                m_skip--;
            end else if (pre > 0) begin
                m_last    = q.pop_front();
                m_sending = 1'b1;
            end
            if (we && (pre != DEPTH)) q.push_back(d);
            m_prev_done = dn;
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [7:0] d, input logic dn);
        @(negedge clk);
        rst = r; wr_en = we; wr_data = d; donetx = dn;
        @(posedge clk);
        #1;
        model_update(r, we, d, dn);
        check("newd", newd, m_sending);
        check("dintx", dintx, m_last);
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        if (newd === 1'b1 && prev_newd !== 1'b1) dut_log.push_back(dintx);
        prev_newd = newd;
    endtask

    task automatic wait_newd();
        int n = 0;
        while (newd !== 1'b1 && n < 40) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            n++;
        end
        check("wait_newd", newd, 1'b1);
    endtask

    task automatic drain(input int frames, input int hold);
        for (int f = 0; f < frames; f++) begin
            wait_newd();
            for (int h = 0; h < hold; h++) step(1'b1, 1'b0, 8'h00, 1'b1);
            step(1'b1, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0);
        dut_log.delete();
    endtask

    initial begin
        int dn_hold;
        logic rr, we, dn;
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; donetx = 1'b0;
        prev_newd = 1'b0;

        // r, we, d, dn | newd, dintx, count, empty, full, ovf
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].dn);
            check($sformatf("tbl%0d_newd", i), newd, tbl[i].e_newd);
            check($sformatf("tbl%0d_dintx", i), dintx, tbl[i].e_dintx);
            check($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
            check($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
        end

        // Burst to full with one byte already in flight, then one dropped write.
        do_reset();
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        wait_newd();
        dut_log.delete();
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        check("burst_full", full, 1'b1);
        check("burst_count", count, 5'd16);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        check("burst_ovf_pulse", overflow, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("burst_ovf_clear", overflow, 1'b0);
        drain(17, 1);
        check("burst_frames", dut_log.size(), 16);
        for (int i = 0; i < dut_log.size(); i++) check("burst_order", dut_log[i], i + 1);
        check("burst_empty", empty, 1'b1);

        // Three rounds of 10 writes and 10 drains wrap the pointers.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'(8'h40 + r * 10 + k), 1'b0);
            drain(10, 1);
        end
        check("wrap_frames", dut_log.size(), 30);
        for (int i = 0; i < dut_log.size(); i++) check("wrap_order", dut_log[i], 8'h40 + i);
        check("wrap_count", count, 5'd0);

        // Write lands on the same edge as a pop with four queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h51 + i), 1'b0);
        check("simul_pre_count", count, 5'd4);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        check("simul_count", count, 5'd4);
        check("simul_dintx", dintx, 8'h52);
        drain(5, 1);
        check("simul_frames", dut_log.size(), 6);
        if (dut_log.size() == 6) check("simul_fifth", dut_log[5], 8'h5A);

        // donetx held high for five cycles retires only one frame.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h61 + i), 1'b0);
        for (int h = 0; h < 5; h++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("long_count", count, 5'd1);
        check("long_newd", newd, 1'b1);
        check("long_dintx", dintx, 8'h62);
        drain(2, 1);

        // Reset while a frame is in flight discards everything queued.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h71 + i), 1'b0);
        check("rstmid_pre_count", count, 5'd3);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        check("rstmid_newd", newd, 1'b0);
        check("rstmid_count", count, 5'd0);
        check("rstmid_empty", empty, 1'b1);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        wait_newd();
        check("rstmid_next", dintx, 8'h3C);
        drain(1, 1);

        // Random traffic with a loosely behaved transmitter and rare resets.
        do_reset();
        dn_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(0, 299) != 0);
            we = ($urandom_range(0, 99) < 55);
            if (dn_hold > 0) begin
                dn = 1'b1;
                dn_hold--;
            end else if ($urandom_range(0, 3) == 0) begin
                dn = 1'b1;
                dn_hold = $urandom_range(0, 3);
            end else begin
                dn = 1'b0;
            end
            step(rr, we, 8'($urandom), dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
